icache_sa: RTL and testbench
============================

# icache_sa

Parametrised set-associative instruction cache between the IF stage and instruction memory. It generalises the direct-mapped 8×4-word fetch cache in four ways: configurable sets, ways and line size; round-robin replacement; a whole-cache flush; and an external refill port instead of an embedded memory. Hits are returned combinationally; misses stall IF via BUSYWAIT while a full line is refilled.

## Interface
- ADDR_WIDTH, 32: fetch address width.
- SETS, 8: number of sets; power of 2, ≥2.
- WAYS, 2: associativity; power of 2, 1..8.
- LINE_WORDS, 4: 32-bit words per line; power of 2, ≥2.
- Derived values:
  - OFF = log2(LINE_WORDS)+2
  - IDX = log2(SETS)
  - TAGW = ADDR_WIDTH-OFF-IDX
- CLK  in  1  clock; all state updates on the negative edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ADDR  in  ADDR_WIDTH  fetch address (PC).
- FLUSH  in  1  invalidate the whole cache.
- INSTRUCTION  out  32  fetched word.
- BUSYWAIT  out  1  stall request to IF.
- MEM_READ  out  1  refill request.
- MEM_ADDR  out  ADDR_WIDTH-OFF  line address of the refill.
- MEM_READ_DATA  in  32*LINE_WORDS  refill line; word 0 in the LSBs.
- MEM_BUSYWAIT  in  1  memory busy; data is valid when low while MEM_READ is high.
- HIT_COUNT  out  32  hit counter (see Configuration).
- MISS_COUNT  out  32  miss counter (see Configuration).

## Operation
- Address fields:
  - ADDR[1:0] ignored.
  - Word select = ADDR[OFF-1:2].
  - Index = ADDR[OFF+IDX-1:OFF].
  - Tag = ADDR[ADDR_WIDTH-1:OFF+IDX].
- Per set: WAYS × {valid, tag, line}, plus a log2(WAYS)-bit round-robin pointer (no pointer when WAYS=1).
- hit (combinational) = any way of the indexed set is valid and its tag matches.
  - At most one way may match; a fill never duplicates a tag.
- INSTRUCTION = selected word of the hit way; 32'h0000_0013 (NOP) when there is no hit.
- BUSYWAIT = (state≠IDLE) | !hit | FLUSH.
- MEM_READ = 1 only in state MEM_RD.
- MEM_ADDR is registered; it holds the latched line address from the miss until the next miss.
- State machine:
  - IDLE:
    - FLUSH → stay in IDLE; clear all valid bits and pointers.
    - Else miss → MEM_RD; latch ADDR tag/index/line address; choose victim.
    - Else stay in IDLE.
  - MEM_RD: MEM_BUSYWAIT=0 → FILL and capture MEM_READ_DATA; else stay.
  - FILL: write line and tag into victim way; set valid; advance the set's pointer if it was used → IDLE.
- Victim choice: lowest-index invalid way; if no way is invalid, the way named by the set's pointer.
  - The pointer increments modulo WAYS only when it supplied the victim.
- Boundary conditions:
  - **FLUSH in MEM_RD or FILL:** clears all valid bits at that edge and sets flush_pend. FILL then writes tag and data but leaves valid=0. flush_pend clears on return to IDLE.
  - **ADDR change during refill:** the fill uses latched fields. In IDLE, hit is re-evaluated against the current ADDR.
  - **Reset (any time):** state=IDLE, all valid=0, pointers=0, flush_pend=0, MEM_READ=0, MEM_ADDR=0, counters=0. BUSYWAIT then reflects the miss (1) while RESET_N is low. Reset mid-refill discards the refill.

## Timing
- Hit: 0 cycles; INSTRUCTION and BUSYWAIT=0 settle combinationally from ADDR.
- Miss, with memory holding MEM_BUSYWAIT high for B negedges in MEM_RD:
  - IDLE→MEM_RD at negedge n.
  - MEM_RD→FILL at negedge n+B+1.
  - FILL→IDLE at n+B+2, at which point BUSYWAIT falls combinationally.
  - Stall = B+2 cycles after detection.
- Memory handshake:
  - MEM_READ rises at the negedge entering MEM_RD and falls at the negedge leaving it.
  - MEM_ADDR is stable throughout.
- FLUSH takes effect at the sampling negedge; the first fetch after it is a miss.

## Configuration
- ICACHE_PERF_CNT_EN defined:
  - HIT_COUNT increments at each negedge in IDLE with hit=1 and FLUSH=0.
  - MISS_COUNT increments on each IDLE→MEM_RD transition.
  - Both saturate at 32'hFFFF_FFFF and are cleared only by reset.
- ICACHE_PERF_CNT_EN undefined: no counter registers; both outputs tied to 0.

## Test plan
- **Cold miss then hit:** reset; ADDR=0x0000_0004; memory B=3 returns line {D3,D2,D1,D0} = {0x33,0x22,0x11,0x00}.
  - MEM_READ for 4 cycles with MEM_ADDR=0x0000_000 (ADDR_WIDTH-OFF bits).
  - BUSYWAIT high for 5 cycles, then INSTRUCTION=0x11.
  - ADDR=0x0000_000C then hits with 0x33.
- **Associativity:** fill 0x0000_0000 and 0x0000_0080 (same index 0, SETS=8, LINE_WORDS=4).
  - Both hit afterwards; MISS_COUNT=2.
- **Round-robin:** a third conflicting line, 0x0000_0100, evicts way 0 (0x000).
  - Refetching 0x000 misses; refetching 0x080 hits.
- **Flush:** FLUSH=1 for one cycle after the above.
  - All previously cached addresses miss; pointers return to 0.
- **Flush mid-refill:** FLUSH pulse during MEM_RD.
  - After FILL the same ADDR misses again, with a new MEM_READ.
- **Async reset mid-refill:** drop RESET_N in MEM_RD.
  - MEM_READ=0 immediately; HIT_COUNT=MISS_COUNT=0; the next fetch misses.

Source files
------------

// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch-side and refill-side signals of the set-associative
// instruction cache. The slave modport is the cache; the master modport is
// the environment (IF stage plus instruction memory).
interface icache_sa_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
);
    localparam int OFF = $clog2(LINE_WORDS) + 2;

    logic [ADDR_WIDTH-1:0]     ADDR;
    logic                      FLUSH;
    logic [31:0]               INSTRUCTION;
    logic                      BUSYWAIT;
    logic                      MEM_READ;
    logic [ADDR_WIDTH-OFF-1:0] MEM_ADDR;
    logic [32*LINE_WORDS-1:0]  MEM_READ_DATA;
    logic                      MEM_BUSYWAIT;
    logic [31:0]               HIT_COUNT;
    logic [31:0]               MISS_COUNT;

    modport master (
        output ADDR, FLUSH, MEM_READ_DATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDR, HIT_COUNT, MISS_COUNT
    );

    modport slave (
        input  ADDR, FLUSH, MEM_READ_DATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDR, HIT_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/icache_sa.sv
// icache_sa: parametrised set-associative instruction cache with round-robin
// replacement, whole-cache flush and an external line-refill port.
// Hits are combinational; misses stall IF through BUSYWAIT during refill.
// All state changes on the falling clock edge.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined;
// otherwise HIT_COUNT and MISS_COUNT are tied to zero.
module icache_sa #(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 8,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input logic         CLK,
    input logic         RESET_N,
    icache_sa_if.slave  bus
);
    localparam int OFF   = $clog2(LINE_WORDS) + 2;
    localparam int IDX   = $clog2(SETS);
    localparam int TAGW  = ADDR_WIDTH - OFF - IDX;
    localparam int WSEL  = OFF - 2;
    localparam int PW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINEW = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        MEM_RD,
        FILL
    } state_t;

    state_t                    state;
    logic [WAYS-1:0]           valid    [SETS];
    logic [TAGW-1:0]           tag_mem  [SETS][WAYS];
    logic [LINEW-1:0]          data_mem [SETS][WAYS];
    logic [PW-1:0]             ptr      [SETS];
    logic                      flush_pend;
    logic                      mem_read_q;
    logic [ADDR_WIDTH-OFF-1:0] mem_addr_q;
    logic [PW-1:0]             fill_way;
    logic                      fill_from_ptr;
    logic [LINEW-1:0]          line_buf;

    logic [WSEL-1:0]           cur_word;
    logic [IDX-1:0]            cur_idx;
    logic [TAGW-1:0]           cur_tag;
    logic [IDX-1:0]            lat_idx;
    logic [TAGW-1:0]           lat_tag;
    logic                      hit;
    logic [PW-1:0]             hit_way;
    logic [PW-1:0]             victim;
    logic                      victim_from_ptr;
    logic [LINEW-1:0]          hit_line;
    logic                      unused_addr_bits;

    assign cur_word         = bus.ADDR[OFF-1:2];
    assign cur_idx          = bus.ADDR[OFF+IDX-1:OFF];
    assign cur_tag          = bus.ADDR[ADDR_WIDTH-1:OFF+IDX];
    assign unused_addr_bits = ^bus.ADDR[1:0];

    // The latched line address already holds {tag, index} of the pending miss.
    assign lat_idx = mem_addr_q[IDX-1:0];
    assign lat_tag = mem_addr_q[ADDR_WIDTH-OFF-1:IDX];

    // Tag compare across all ways of the currently indexed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[cur_idx][w] && (tag_mem[cur_idx][w] == cur_tag)) begin
                hit     = 1'b1;
                hit_way = PW'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        victim          = ptr[cur_idx];
        victim_from_ptr = 1'b1;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (victim_from_ptr && !valid[cur_idx][w]) begin
                victim          = PW'(w);
                victim_from_ptr = 1'b0;
            end
        end
    end

    assign hit_line        = data_mem[cur_idx][hit_way];
    assign bus.INSTRUCTION = hit ? hit_line[{cur_word, 5'b0} +: 32] : 32'h0000_0013;
    assign bus.BUSYWAIT    = (state != IDLE) | ~hit | bus.FLUSH;
    assign bus.MEM_READ    = mem_read_q;
    assign bus.MEM_ADDR    = mem_addr_q;

    // Refill controller: miss detection, memory handshake, line install, flush.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            flush_pend    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_addr_q    <= '0;
            fill_way      <= '0;
            fill_from_ptr <= 1'b0;
            line_buf      <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                ptr[s]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.FLUSH) begin
                        for (int unsigned s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            ptr[s]   <= '0;
                        end
                    end else if (!hit) begin
                        state         <= MEM_RD;
                        mem_read_q    <= 1'b1;
                        mem_addr_q    <= bus.ADDR[ADDR_WIDTH-1:OFF];
                        fill_way      <= victim;
                        fill_from_ptr <= victim_from_ptr;
                    end
                end
                MEM_RD: begin
                    if (bus.FLUSH) begin
                        for (int unsigned s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                        end
                        flush_pend <= 1'b1;
                    end
                    if (!bus.MEM_BUSYWAIT) begin
                        state      <= FILL;
                        mem_read_q <= 1'b0;
                        line_buf   <= bus.MEM_READ_DATA;
                    end
                end
                FILL: begin
                    if (bus.FLUSH) begin
                        for (int unsigned s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                        end
                    end
                    // A flush seen during this refill installs the line invalid.
                    valid[lat_idx][fill_way] <= !(flush_pend || bus.FLUSH);
                    if ((WAYS > 1) && fill_from_ptr) begin
                        ptr[lat_idx] <= ptr[lat_idx] + 1'b1;
                    end
                    flush_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and line storage; written only while installing a refilled line.
    always_ff @(negedge CLK) begin
        if (state == FILL) begin
            tag_mem[lat_idx][fill_way]  <= lat_tag;
            data_mem[lat_idx][fill_way] <= line_buf;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    // Saturating hit/miss counters, sampled only while idle.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == IDLE) && !bus.FLUSH) begin
            if (hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (!hit && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign bus.HIT_COUNT  = hit_cnt;
    assign bus.MISS_COUNT = miss_cnt;
`else
    assign bus.HIT_COUNT  = '0;
    assign bus.MISS_COUNT = '0;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: self-checking bench for icache_sa (SETS=8, WAYS=2, LINE_WORDS=4).
// Table-driven test-plan vectors, hand sequences for flush/reset during refill,
// and randomized fetches checked against an address-level cache model.
module tb_icache_sa;
    localparam int AW    = 32;
    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int LW    = 4;
    localparam int OFF   = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    icache_sa_if #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) bus ();

    icache_sa #(.ADDR_WIDTH(AW), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LW)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Instruction memory contents: word j of line la.
    function automatic logic [31:0] mem_word(input logic [AW-OFF-1:0] la, input int unsigned j);
        logic [7:0] lo;
        lo = 8'(j * 17);
        return {la[19:0], 4'h0, lo};
    endfunction

    function automatic logic [32*LW-1:0] line_of(input logic [AW-OFF-1:0] la);
        logic [32*LW-1:0] l;
        for (int j = 0; j < LW; j++) l[j*32 +: 32] = mem_word(la, j);
        return l;
    endfunction

    // Memory responder: holds busy for mem_lat cycles per request, then returns the line.
    int unsigned mem_lat = 0;
    int unsigned wait_cnt = 0;
    always @(posedge CLK) begin
        if (bus.MEM_READ) begin
            if (wait_cnt < mem_lat) begin
                bus.MEM_BUSYWAIT = 1'b1;
                wait_cnt++;
            end else begin
                bus.MEM_BUSYWAIT  = 1'b0;
                bus.MEM_READ_DATA = line_of(bus.MEM_ADDR);
            end
        end else begin
            wait_cnt = 0;
            bus.MEM_BUSYWAIT = 1'b1;
        end
    end

    // Reference model: per set, which tags are resident and the replacement pointer.
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int unsigned m_ptr   [SETS];
    int unsigned exp_hits = 0;
    int unsigned exp_miss = 0;

    function automatic int unsigned set_of(input logic [31:0] a);
        return (a / 16) % SETS;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (16 * SETS);
    endfunction

    function automatic bit m_lookup(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_victim(input logic [31:0] a, output int unsigned way, output bit used);
        used = 1'b1;
        way  = m_ptr[set_of(a)];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!m_valid[set_of(a)][w]) begin way = w; used = 1'b0; end
    endtask

    task automatic m_commit(input logic [31:0] a, input int unsigned way, input bit used, input bit keep);
        m_tag[set_of(a)][way]   = tag_of(a);
        m_valid[set_of(a)][way] = keep;
        if (used) m_ptr[set_of(a)] = (m_ptr[set_of(a)] + 1) % WAYS;
    endtask

    task automatic m_clear_valid();
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic m_flush_all();
        m_clear_valid();
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge (mid-way between active falling edges).
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_counters(input string name);
`ifdef ICACHE_PERF_CNT_EN
        check({name, "_hits"}, 64'(bus.HIT_COUNT), 64'(exp_hits));
        check({name, "_miss"}, 64'(bus.MISS_COUNT), 64'(exp_miss));
`else
        check({name, "_hits"}, 64'(bus.HIT_COUNT), 64'd0);
        check({name, "_miss"}, 64'(bus.MISS_COUNT), 64'd0);
`endif
    endtask

    // One fetch: a hit is checked in place; a miss is followed through the refill.
    task automatic fetch(input logic [31:0] a, input int unsigned b, input bit exp_hit,
                         input logic [31:0] exp_instr, input bit scramble, input string nm);
        int unsigned way, rd, bz, n;
        bit used, done, addr_bad;
        bus.ADDR = a;
        mem_lat  = b;
        #1;
        if (exp_hit) begin
            check({nm, "_hit_busy"}, 64'(bus.BUSYWAIT), 64'd0);
            check({nm, "_hit_instr"}, 64'(bus.INSTRUCTION), 64'(exp_instr));
            cycle();
            exp_hits++;
        end else begin
            check({nm, "_miss_busy"}, 64'(bus.BUSYWAIT), 64'd1);
            check({nm, "_miss_nop"}, 64'(bus.INSTRUCTION), 64'(NOP));
            m_victim(a, way, used);
            rd = 0; bz = 0; n = 0; done = 1'b0; addr_bad = 1'b0;
            while (!done && n < 100) begin
                cycle();
                n++;
                if (bus.MEM_READ) begin
                    rd++;
                    if (bus.MEM_ADDR !== a[31:OFF]) addr_bad = 1'b1;
                    if (scramble && rd == 1) bus.ADDR = $urandom;
                end else if (bus.BUSYWAIT) begin
                    bus.ADDR = a;
                end
                if (bus.BUSYWAIT) bz++;
                else done = 1'b1;
            end
            check({nm, "_refill_done"}, 64'(done), 64'd1);
            check({nm, "_memread_cycles"}, 64'(rd), 64'(b + 1));
            check({nm, "_stall_cycles"}, 64'(bz), 64'(b + 2));
            check({nm, "_mem_addr"}, 64'(addr_bad), 64'd0);
            check({nm, "_fill_instr"}, 64'(bus.INSTRUCTION), 64'(exp_instr));
            exp_miss++;
            m_commit(a, way, used, 1'b1);
        end
    endtask

    task automatic fetch_m(input logic [31:0] a, input int unsigned b, input bit scramble, input string nm);
        fetch(a, b, m_lookup(a), mem_word(a[31:OFF], a[3:2]), scramble, nm);
    endtask

    task automatic do_flush();
        bus.FLUSH = 1'b1;
        #1;
        check("flush_busy", 64'(bus.BUSYWAIT), 64'd1);
        cycle();
        bus.FLUSH = 1'b0;
        m_flush_all();
    endtask

    typedef struct {
        logic [31:0] addr;
        int unsigned lat;
        bit          hit;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int unsigned way, n;
        bit used;
        logic [31:0] a;

        tbl[0]  = '{32'h0000_0004, 3, 1'b0, 32'h0000_0011};
        tbl[1]  = '{32'h0000_000C, 0, 1'b1, 32'h0000_0033};
        tbl[2]  = '{32'h0000_0000, 0, 1'b1, 32'h0000_0000};
        tbl[3]  = '{32'h0000_0080, 2, 1'b0, 32'h0000_8000};
        tbl[4]  = '{32'h0000_0084, 0, 1'b1, 32'h0000_8011};
        tbl[5]  = '{32'h0000_0008, 0, 1'b1, 32'h0000_0022};
        tbl[6]  = '{32'h0000_0100, 1, 1'b0, 32'h0001_0000};
        tbl[7]  = '{32'h0000_0088, 0, 1'b1, 32'h0000_8022};
        tbl[8]  = '{32'h0000_0000, 0, 1'b0, 32'h0000_0000};
        tbl[9]  = '{32'h0000_008C, 0, 1'b0, 32'h0000_8033};
        tbl[10] = '{32'h0000_0004, 0, 1'b1, 32'h0000_0011};

        bus.ADDR  = '0;
        bus.FLUSH = 1'b0;
        m_flush_all();

        // Reset state
        #2;
        check("rst_mem_read", 64'(bus.MEM_READ), 64'd0);
        check("rst_mem_addr", 64'(bus.MEM_ADDR), 64'd0);
        check("rst_busy", 64'(bus.BUSYWAIT), 64'd1);
        check("rst_instr", 64'(bus.INSTRUCTION), 64'(NOP));
        check_counters("rst");
        cycle();
        RESET_N = 1'b1;

        // Test-plan vectors: cold miss, associativity, round-robin eviction
        for (int i = 0; i < 11; i++) begin
            fetch(tbl[i].addr, tbl[i].lat, tbl[i].hit, tbl[i].instr, 1'b0, $sformatf("tbl%0d", i));
            if (i == 5) check_counters("assoc");
        end
        check_counters("table");

        // Flush: everything misses and replacement restarts from way 0
        do_flush();
        fetch_m(32'h0000_000C, 1, 1'b0, "pf_0c");
        fetch_m(32'h0000_0084, 1, 1'b0, "pf_84");
        fetch_m(32'h0000_0100, 1, 1'b0, "pf_100");
        fetch_m(32'h0000_0080, 0, 1'b0, "pf_80");
        fetch_m(32'h0000_0000, 0, 1'b0, "pf_00");

        // Flush pulse while the refill is outstanding
        a = 32'h0000_02A0;
        bus.ADDR = a;
        mem_lat = 4;
        m_victim(a, way, used);
        cycle();
        check("fmr_memread", 64'(bus.MEM_READ), 64'd1);
        cycle();
        bus.FLUSH = 1'b1;
        cycle();
        bus.FLUSH = 1'b0;
        m_clear_valid();
        n = 0;
        while (bus.MEM_READ && n < 50) begin cycle(); n++; end
        check("fmr_memread_fell", 64'(bus.MEM_READ), 64'd0);
        m_commit(a, way, used, 1'b0);
        exp_miss++;
        cycle();
        check("fmr_idle_busy", 64'(bus.BUSYWAIT), 64'd1);
        check("fmr_idle_nop", 64'(bus.INSTRUCTION), 64'(NOP));
        m_victim(a, way, used);
        cycle();
        check("fmr_rerequest", 64'(bus.MEM_READ), 64'd1);
        check("fmr_rerequest_addr", 64'(bus.MEM_ADDR), 64'(a[31:OFF]));
        n = 0;
        while (bus.BUSYWAIT && n < 50) begin cycle(); n++; end
        check("fmr_second_fill", 64'(bus.INSTRUCTION), 64'(mem_word(a[31:OFF], 0)));
        m_commit(a, way, used, 1'b1);
        exp_miss++;
        check_counters("fmr");

        // Asynchronous reset while waiting on memory
        bus.ADDR = 32'h0000_03C4;
        mem_lat = 10;
        cycle();
        cycle();
        check("arst_pre_memread", 64'(bus.MEM_READ), 64'd1);
        RESET_N = 1'b0;
        #1;
        check("arst_memread", 64'(bus.MEM_READ), 64'd0);
        check("arst_busy", 64'(bus.BUSYWAIT), 64'd1);
        m_flush_all();
        exp_hits = 0;
        exp_miss = 0;
        check_counters("arst");
        cycle();
        RESET_N = 1'b1;
        fetch_m(32'h0000_000C, 1, 1'b0, "arst_next");
        check("arst_next_was_miss", 64'(exp_miss), 64'd1);

        // Randomized fetch stream over a small, conflicting address pool
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush();
            end else begin
                a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 2) << 4) |
                    ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
                fetch_m(a, $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
            end
        end
        check_counters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
